// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, data width and
// the helpers that derive and validate the clocks-per-bit divider.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Clocks per bit, integer division of the clock rate by the line rate.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Mid-bit sampling needs enough clocks per bit to land clear of the edges.
    function automatic bit div_ok(input int div);
        return div >= MIN_DIV;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side interface of the UART receiver: valid/ready byte stream, error
// pulses, activity flag and the FSM state for observation.
//
// Handshake: the receiver raises o_valid with o_data and holds both stable
// until a rising clock edge sees o_valid & i_ready; that edge transfers the
// byte. o_valid never drops without such a transfer (or a reset). i_ready may
// be asserted at any time, independent of o_valid.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_busy;
    state_t               state;

    modport master (
        output o_data, o_valid, o_frame_err, o_overrun, o_busy, state,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_frame_err, o_overrun, o_busy, state,
        output i_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input. RST_VAL sets
// the value both flops take in reset, so an idle-high line reads idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; only q is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Samples the synchronised line at mid-bit,
// presents each good byte in a single holding register behind a valid/ready
// handshake, and pulses frame-error / overrun flags for the status logic.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 24000000,
    parameter int BAUD     = 115200
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_uart_rx,
    uart_rx_if.master  bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    generate
        if (!div_ok(DIV)) begin : g_div_check
            $error("uart_rx: CLK_FREQ/BAUD must be at least 8 clocks per bit");
        end
    endgenerate

    logic                 rx_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 accept;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (i_clk),
        .rst (i_res),
        .d   (i_uart_rx),
        .q   (rx_s)
    );

    assign accept    = bus.o_valid & bus.i_ready;
    assign bus.state = state;

    // Receive FSM, bit timing, shift register and the byte holding register.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_overrun   <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            bus.o_frame_err <= 1'b0;
            bus.o_overrun   <= 1'b0;

            // A transfer empties the holding register unless a delivery
            // on this same edge refills it (STOP branch below wins).
            if (accept) begin
                bus.o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state      <= START;
                        bus.o_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // Line was back high at mid start bit: a glitch.
                            state      <= IDLE;
                            bus.o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state      <= IDLE;
                            bus.o_busy <= 1'b0;
                            if (!bus.o_valid || bus.i_ready) begin
                                bus.o_data  <= shreg;
                                bus.o_valid <= 1'b1;
                            end else begin
                                // Holding register still owned by consumer.
                                bus.o_overrun <= 1'b1;
                            end
                        end else begin
                            state           <= BREAK;
                            bus.o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // cannot be mistaken for a stream of start bits.
                    cnt <= '0;
                    if (rx_s) begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first: the receive-side counterpart of the monitor's existing UART transmit path.
- Deserialises the host command line into bytes and presents them on a valid/ready byte interface to the command decoder.
- Reports framing errors and overruns as one-cycle pulses, which the status/LED logic latches.

Parameters:
- CLK_FREQ, 24000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- DIV, CLK_FREQ/BAUD (integer division, =208 at defaults): clocks per bit. Must be >= 8; elaboration fails otherwise.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_res  in  1  synchronous reset, active-high.
- i_uart_rx  in  1  asynchronous serial line; idle high.
- o_data  out  8  received byte; stable while o_valid=1.
- o_valid  out  1  byte available; held until accepted.
- i_ready  in  1  consumer accepts the byte when o_valid & i_ready at a clock edge.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: byte completed while o_valid still held; the new byte is dropped.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Synchroniser:
  - Two-flop synchroniser on i_uart_rx, both flops reset to 1.
  - rx_s is the second flop's output; all decisions use rx_s.
- Reset (i_res=1 at an edge), takes effect on the next edge regardless of state, including mid-frame:
  - state=IDLE, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Counters, bit index and shift register cleared; a partial frame is discarded.
- Bit-timing counter:
  - cnt counts 0..DIV-1.
  - A "tick" occurs when cnt reaches its terminal value; cnt then reloads to 0.
- State machine:
  - IDLE: rx_s=0 (falling edge from idle) -> START, cnt=0.
  - START: at cnt=DIV/2-1, sample rx_s.
    - 0 -> DATA, bit index=0, cnt=0.
    - 1 -> IDLE (glitch rejected, no output).
  - DATA: at each cnt=DIV-1 (mid-bit), shift rx_s into bit 7 of the shift register, shifting right, so the first received bit lands in bit 0.
    - After the 8th sample -> STOP, cnt=0.
  - STOP: at cnt=DIV-1, sample rx_s.
    - 1 -> deliver the byte (see handshake), then IDLE.
    - 0 -> o_frame_err=1 for one cycle, byte discarded, then BREAK.
  - BREAK: remain until rx_s=1, then IDLE. A held-low line does not retrigger frames.
- Handshake and buffering (single holding register):
  - Delivery with o_valid=0: o_data<=shift register and o_valid<=1 on the same edge that leaves STOP.
  - Delivery with o_valid=1 and i_ready=0: o_data unchanged, o_valid stays 1, o_overrun=1 for one cycle.
  - Delivery with o_valid=1 and i_ready=1 on the same edge: accept and reload together. o_data takes the new byte, o_valid stays 1, no overrun.
  - No delivery and o_valid & i_ready: o_valid<=0, o_data holds its last value.
  - o_valid must not drop without an accept or a reset.
- Latency:
  - Line falling edge to START entry: 3 clocks (2 synchroniser flops + IDLE detect).
  - Stop-bit mid sample to o_valid=1: 1 clock.
- Error priority: a frame error never sets o_valid. When a frame error occurs, o_overrun is not asserted.
- Width rules:
  - cnt width is $clog2(DIV).
  - Bit index is 3 bits.
  - No arithmetic wrap beyond DIV-1.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - Function calc_div(clk, baud) and the DIV>=8 check.
  - Constant DATA_BITS=8.
- One natural sub-module: sync_2ff, the generic two-flop synchroniser with a reset value parameter, reused by the I2C input path.
- Bit counter and FSM stay in uart_rx.

Test Plan (CLK_FREQ=16, BAUD=1, so DIV=16):
- Clean frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1, i_ready held 1 -> o_valid pulses 1 cycle with o_data=0xA5. Pulse occurs 1 clock after stop mid-sample. o_frame_err=0.
- Line low for 3 clocks, then high -> START aborts at the mid-sample, returns to IDLE. No o_valid, o_busy drops within DIV/2+3 clocks.
- Frame 0x3C with stop bit low, line then held low 40 clocks, then released high -> o_frame_err one-cycle pulse, no o_valid. FSM stays in BREAK until release, then a following 0x55 frame is received correctly.
- i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_valid stays 1, o_overrun pulses once at the end of the 0x22 frame. Assert i_ready: o_valid drops, o_data stays 0x11.
- o_valid=1 holding 0x11, i_ready asserted exactly on the edge that completes 0x22 -> o_data=0x22, o_valid stays 1, o_overrun=0.
- i_res pulsed mid-DATA of frame 0x99 -> all outputs 0 the next cycle, o_busy=0. The next full frame 0x42 is received as 0x42.
